// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the MIPS CPU HI/LO multiply-divide unit.
//   - funct field codes for the HI/LO instructions handled by the unit
//   - muldiv_state_t: control FSM states (IDLE, MUL, DIV, FIX)
package mips_cpu_pkg;

  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } muldiv_state_t;

endpackage

// File: rtl/mips_cpu_muldiv_divider.sv
// Iterative magnitude engine: restoring divider, one quotient bit per cycle.
// When mul_i is set at start it runs a shift-add multiply instead, reusing
// the same accumulator/shift registers and iteration counter.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   start_i, mul_i  load operands and begin (mul_i selects multiply)
//   a_i, b_i        dividend/multiplier, divisor/multiplicand (magnitudes)
//   done_o          high during the cycle whose edge performs the last step
//   hi_o, lo_o      remainder / quotient (divide) or product high/low (multiply)
module mips_cpu_muldiv_divider #(
  parameter int DATA_W = 32,
  parameter int ITERS  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              mul_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              done_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int CNT_W = $clog2(ITERS);

  logic              run_q, mul_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] acc_q, lo_q, b_q;
  logic [DATA_W:0]   rem_sh, diff, sum;

  // divide: shift the next dividend bit into the partial remainder, trial subtract
  assign rem_sh = {acc_q, lo_q[DATA_W-1]};
  assign diff   = rem_sh - {1'b0, b_q};
  // multiply: add multiplicand when the current multiplier bit is set
  assign sum    = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);

  assign done_o = run_q && (cnt_q == CNT_W'(ITERS-1));
  assign hi_o   = acc_q;
  assign lo_o   = lo_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q <= 1'b0;
      mul_q <= 1'b0;
      cnt_q <= '0;
      acc_q <= '0;
      lo_q  <= '0;
      b_q   <= '0;
    end else if (start_i) begin
      run_q <= 1'b1;
      mul_q <= mul_i;
      cnt_q <= '0;
      acc_q <= '0;
      lo_q  <= a_i;
      b_q   <= b_i;
    end else if (run_q) begin
      cnt_q <= cnt_q + 1'b1;
      if (done_o) run_q <= 1'b0;
      if (mul_q) begin
        acc_q <= sum[DATA_W:1];
        lo_q  <= {sum[0], lo_q[DATA_W-1:1]};
      end else if (!diff[DATA_W]) begin
        acc_q <= diff[DATA_W-1:0];
        lo_q  <= {lo_q[DATA_W-2:0], 1'b1};
      end else begin
        acc_q <= rem_sh[DATA_W-1:0];
        lo_q  <= {lo_q[DATA_W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mips_cpu_muldiv.sv
// HI/LO multiply-divide unit: executes MULT, MULTU, DIV, DIVU, MTHI, MTLO,
// owns the architectural HI/LO registers and stalls the datapath via busy.
// Build option: MULDIV_FAST_MUL_EN selects a single-cycle combinational
// multiply; otherwise multiply is iterative on the shared divider engine.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   start, funct    issue strobe and instruction funct field
//   rs_val, rt_val  source operands
//   busy            operation in progress (registered)
//   hi, lo          architectural HI / LO
module mips_cpu_muldiv
  import mips_cpu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  output logic              busy,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  muldiv_state_t     state_q, state_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;

  // operation flags captured at issue for the final fixup
  logic              mul_q, neg_q, rneg_q, dz_q;
  logic [DATA_W-1:0] rs_q;

  logic is_mul, is_div, sgn, accept, eng_start, eng_done;
  logic [DATA_W-1:0]   eng_hi, eng_lo;
  logic [2*DATA_W-1:0] eng_prod;

  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x, input logic s);
    return (s && x[DATA_W-1]) ? (~x + 1'b1) : x;
  endfunction

  assign is_mul = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU);
  assign is_div = (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
  assign sgn    = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
  assign accept = start && (state_q == IDLE);

`ifdef MULDIV_FAST_MUL_EN
  logic              sgn_q;
  logic [DATA_W-1:0] rt_q;
  logic [2*DATA_W-1:0] fast_prod;
  assign fast_prod = {{DATA_W{sgn_q & rs_q[DATA_W-1]}}, rs_q}
                   * {{DATA_W{sgn_q & rt_q[DATA_W-1]}}, rt_q};
  assign eng_start = accept && is_div;

  always_ff @(posedge clk) begin
    if (reset) begin
      sgn_q <= 1'b0;
      rt_q  <= '0;
    end else if (accept && is_mul) begin
      sgn_q <= sgn;
      rt_q  <= rt_val;
    end
  end
`else
  assign eng_start = accept && (is_div || is_mul);
`endif

  mips_cpu_muldiv_divider #(
    .DATA_W (DATA_W),
    .ITERS  (DIV_CYCLES)
  ) u_divider (
    .clk     (clk),
    .reset   (reset),
    .start_i (eng_start),
    .mul_i   (is_mul),
    .a_i     (mag(rs_val, sgn)),
    .b_i     (mag(rt_val, sgn)),
    .done_o  (eng_done),
    .hi_o    (eng_hi),
    .lo_o    (eng_lo)
  );

  assign eng_prod = {eng_hi, eng_lo};

  // state register and architectural outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mul_q  <= 1'b0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
      rs_q   <= '0;
    end else if (accept && (is_mul || is_div)) begin
      mul_q  <= is_mul;
      neg_q  <= sgn && (rs_val[DATA_W-1] ^ rt_val[DATA_W-1]);
      rneg_q <= sgn && rs_val[DATA_W-1];
      dz_q   <= (rt_val == '0);
      rs_q   <= rs_val;
    end
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) begin
        if (is_mul)      state_d = MUL;
        else if (is_div) state_d = DIV;
      end
`ifdef MULDIV_FAST_MUL_EN
      MUL:  state_d = IDLE;
`else
      MUL:  if (eng_done) state_d = FIX;
`endif
      DIV:  if (eng_done) state_d = FIX;
      FIX:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs: HI/LO only move on MTHI/MTLO or on completion
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    busy_d = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (start && funct == FUNCT_MTHI) hi_d = rs_val;
        if (start && funct == FUNCT_MTLO) lo_d = rs_val;
      end
`ifdef MULDIV_FAST_MUL_EN
      MUL: {hi_d, lo_d} = fast_prod;
`endif
      FIX: begin
        if (mul_q) begin
          {hi_d, lo_d} = neg_q ? (~eng_prod + 1'b1) : eng_prod;
        end else if (dz_q) begin
          hi_d = rs_q;
          lo_d = '1;
        end else begin
          lo_d = neg_q  ? (~eng_lo + 1'b1) : eng_lo;
          hi_d = rneg_q ? (~eng_hi + 1'b1) : eng_hi;
        end
      end
      default: ;
    endcase
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
module tb_mips_cpu_muldiv;
  import mips_cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [5:0]  funct;
  logic [31:0] rs_val, rt_val;
  logic        busy;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  mips_cpu_muldiv dut (
    .clk(clk), .reset(reset), .start(start), .funct(funct),
    .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural reference: plain arithmetic on the ISA semantics.
  task automatic ref_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] eh, output logic [31:0] el, output int lat);
    longint      sp;
    longint unsigned up;
    int          sa, sb;
    int unsigned ua, ub;
    eh = 0; el = 0; lat = 33;
    sa = a; sb = b; ua = a; ub = b;
    case (f)
      FUNCT_MULT: begin
        sp = longint'(sa) * longint'(sb);
        {eh, el} = sp; lat = MUL_LAT;
      end
      FUNCT_MULTU: begin
        up = longint'(ua) * longint'(ub);
        {eh, el} = up; lat = MUL_LAT;
      end
      FUNCT_DIV: begin
        if (b == 0) begin el = 32'hFFFF_FFFF; eh = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin el = a; eh = 0; end
        else begin el = sa / sb; eh = sa % sb; end
      end
      default: begin
        if (b == 0) begin el = 32'hFFFF_FFFF; eh = a; end
        else begin el = ua / ub; eh = ua % ub; end
      end
    endcase
  endtask

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; funct = f; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0; funct = 6'b0; rs_val = $urandom; rt_val = $urandom;
  endtask

  // Issue an arithmetic op, measure busy width, check outputs held then result.
  task automatic run_op(input string tag, input logic [5:0] f,
                        input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh, el, ph, pl;
    int lat, n;
    bit held;
    ref_op(f, a, b, eh, el, lat);
    ph = hi; pl = lo;
    issue(f, a, b);
    n = 0; held = 1'b1;
    while (busy && n < 100) begin
      if (hi !== ph || lo !== pl) held = 1'b0;
      n++;
      @(negedge clk);
    end
    chk({tag, " held"}, 32'(held), 32'd1);
    chk({tag, " busy_width"}, n, lat);
    chk({tag, " hi"}, hi, eh);
    chk({tag, " lo"}, lo, el);
  endtask

  initial begin
    logic [5:0]  ops [4];
    logic [31:0] a, b, eh, el;
    int lat, n;
    ops[0] = FUNCT_MULT; ops[1] = FUNCT_MULTU; ops[2] = FUNCT_DIV; ops[3] = FUNCT_DIVU;
    reset = 1'b1; start = 1'b0; funct = 6'b0; rs_val = 0; rt_val = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset busy", 32'(busy), 0);
    chk("reset hi", hi, 0);
    chk("reset lo", lo, 0);

    issue(FUNCT_MTHI, 32'h1234_5678, 0);
    chk("mthi busy", 32'(busy), 0);
    issue(FUNCT_MTLO, 32'hDEAD_BEEF, 0);
    chk("mtlo busy", 32'(busy), 0);
    chk("mthi hi", hi, 32'h1234_5678);
    chk("mtlo lo", lo, 32'hDEAD_BEEF);

    issue(6'b100000, 32'h5555_5555, 1);
    chk("badfunct busy", 32'(busy), 0);
    chk("badfunct hi", hi, 32'h1234_5678);
    chk("badfunct lo", lo, 32'hDEAD_BEEF);

    run_op("mult -2*3", FUNCT_MULT, 32'hFFFF_FFFE, 3);
    run_op("multu", FUNCT_MULTU, 32'hFFFF_FFFE, 3);
    run_op("div -7/2", FUNCT_DIV, 32'hFFFF_FFF9, 2);
    run_op("divu 100/7", FUNCT_DIVU, 100, 7);
    run_op("div by 0", FUNCT_DIV, 5, 0);
    run_op("div neg by 0", FUNCT_DIV, 32'hFFFF_FFFB, 0);
    run_op("div ovf", FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu max", FUNCT_DIVU, 32'hFFFF_FFFF, 1);
    run_op("mult min", FUNCT_MULT, 32'h8000_0000, 32'h8000_0000);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 0;
        1: b = $urandom_range(1, 20);
        2: b = -$urandom_range(1, 20);
        default: b = $urandom;
      endcase
      run_op($sformatf("rand%0d f=%b", i, ops[i % 4]), ops[i % 4], a, b);
    end

    // a second start while busy must be ignored
    ref_op(FUNCT_DIVU, 1000, 3, eh, el, lat);
    issue(FUNCT_DIVU, 1000, 3);
    repeat (9) @(negedge clk);
    start = 1'b1; funct = FUNCT_MTLO; rs_val = 9;
    @(negedge clk);
    start = 1'b0; funct = 6'b0;
    n = 0;
    while (busy && n < 100) begin n++; @(negedge clk); end
    chk("ignore busy_end", n, 23);
    chk("ignore hi", hi, eh);
    chk("ignore lo", lo, el);

    // reset aborts an in-flight divide
    issue(FUNCT_DIVU, 32'h0BAD_F00D, 17);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort busy", 32'(busy), 0);
    chk("abort hi", hi, 0);
    chk("abort lo", lo, 0);
    run_op("post-reset multu 6*7", FUNCT_MULTU, 6, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
